fp_mul_issue: RTL and testbench
===============================

# fp_mul_issue

Upstream issue stage for the sequential IEEE-754 single-precision multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It issues one pair at a time to the multiplier with a single-cycle start pulse, waits for the multiplier's one-cycle `done`, and presents the result with its tag on a valid/ready output. The multiplier is not pipelined; this block serialises requests so producers need not track its variable latency.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; power of two, at least 2.
- `TAG_W`, 4: width of the user tag carried alongside each request.
- `TIMEOUT`, 255: maximum cycles in WAIT before the watchdog fires, range 1..511.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: **asynchronous, active-low reset**.
- `in_valid`  in  1: an operand pair is offered.
- `in_ready`  out  1: the FIFO can accept; equals `!full`.
- `in_op1`, `in_op2`  in  32 each: IEEE-754 operands.
- `in_tag`  in  TAG_W: request tag.
- `mul_ready`  out  1: start pulse to the multiplier, one cycle.
- `mul_op1`, `mul_op2`  out  32 each: operands, registered.
- `mul_res`  in  32: multiplier result.
- `mul_done`  in  1: multiplier completion pulse, one cycle.
- `out_valid`  out  1: a result is held.
- `out_ready`  in  1: the consumer takes the result.
- `out_res`  out  32: product.
- `out_tag`  out  TAG_W: tag of the product.
- `busy`  out  1: high when the FSM is not IDLE or the FIFO is non-empty.
- `err_timeout`  out  1: sticky watchdog flag.

## Operation
- **FIFO**
  - Holds {op1, op2, tag} entries with separate read and write pointers of log2(DEPTH)+1 bits; bit-MSB differences give wrap-around full/empty detection.
  - Push on `in_valid && in_ready`; pop only in the ISSUE transition.
  - Push and pop in the same cycle are both allowed, except that push is blocked while full even if a pop occurs. There is no full-bypass.
- **FSM states**
  - IDLE: if the FIFO is non-empty and the output slot is free (`!out_valid || out_ready`), go to ISSUE; load `mul_op1`, `mul_op2` and the tag register from the FIFO head and pop.
  - ISSUE: `mul_ready`=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold `mul_op*` stable. When `mul_done`=1, capture `mul_res` into `out_res`, the tag into `out_tag`, set `out_valid`, and go to IDLE.
- **Output slot:** `out_valid` clears on `out_valid && out_ready` unless it is reloaded in the same cycle.
  - Because issue requires a free slot, a `mul_done` capture never overwrites an unconsumed result.
- **Unsolicited pulses:** `mul_done` outside WAIT is ignored.
- **Reset:** asynchronous and immediate, mid-operation included. The FSM goes to IDLE, the FIFO empties, and all outputs go to 0.
  - The multiplier is reset by the same net, so no in-flight result survives.

## Timing
- **Reset values:** `in_ready`=1, `mul_ready`=0, `mul_op1`/`mul_op2`=0, `out_valid`=0, `out_res`=0, `out_tag`=0, `busy`=0, `err_timeout`=0.
- **Push to start:** push into an empty FIFO at edge N → IDLE sees non-empty in cycle N+1 → `mul_ready`=1 in cycle N+2.
- **Operand hold:** the multiplier samples operands on the edge ending the ISSUE cycle; `mul_op*` stay stable until WAIT exits.
- **Done to output:** `mul_done` high in cycle M → `out_valid`=1 from cycle M+1.
- **Back-to-back:** the next ISSUE comes no earlier than cycle M+2, matching the multiplier's FINISH→START return.
- **Throughput:** one product per multiplier latency + 3 cycles.

## Configuration
- `FP_MUL_ISSUE_TIMEOUT_EN` defined:
  - A 9-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `mul_done`, set `err_timeout` (sticky until reset), drop the request with no output, and return to IDLE.
- Undefined: WAIT has no bound, there is no counter logic, and `err_timeout` is tied to 0.
- The default `TIMEOUT` of 255 exceeds the multiplier's worst-case subnormal normalisation latency.

## Test plan
- **Basic product:** push 0x3F800000 × 0x40000000 with tag 0x3 and `out_ready`=1 → `mul_ready` is one cycle wide, 2 cycles after the push; `out_res`=0x40000000 and `out_tag`=0x3 the cycle after `mul_done`.
- **Back-to-back ordering:** push 0x40400000×0x40800000 then 0x40000000×0xC0000000 → outputs 0x41400000 then 0xC0800000, in order; the second `mul_ready` comes 2 cycles after the first `mul_done`.
- **Special operands:** 0x00000000 × 0x7F800000 → `out_res`=0xFFC00000; `busy` drops to 0 after the result is consumed.
- **Backpressure and full:** hold `out_ready`=0 and stream 8 pairs with DEPTH=4 → exactly 5 accepted, then `in_ready`=0, with only one `mul_ready` pulse. Release `out_ready` → all 5 results drain in order, and `in_ready` returns to 1 after the first pop.
- **Watchdog:** with `FP_MUL_ISSUE_TIMEOUT_EN` defined, tie `mul_done`=0 → `err_timeout`=1 exactly `TIMEOUT` cycles after entering WAIT, FSM back in IDLE, and no `out_valid`. Without the macro → `err_timeout` stays 0.
- **Reset mid-operation:** pull `rst` low during WAIT with 2 entries queued → all outputs go to their reset values immediately; after release, `in_ready`=1 and no stale result appears.

Source files
------------

// File: rtl/fp_mul_issue_if.sv
// rtl/fp_mul_issue_if.sv - operand, multiplier and result stream signals of fp_mul_issue
interface fp_mul_issue_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_op1;
  logic [31:0]      in_op2;
  logic [TAG_W-1:0] in_tag;

  logic             mul_ready;
  logic [31:0]      mul_op1;
  logic [31:0]      mul_op2;
  logic [31:0]      mul_res;
  logic             mul_done;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;

  // Issue-stage side
  modport slave (
    input  in_valid, in_op1, in_op2, in_tag, mul_res, mul_done, out_ready,
    output in_ready, mul_ready, mul_op1, mul_op2, out_valid, out_res, out_tag
  );

  // Producer / multiplier / consumer side
  modport master (
    output in_valid, in_op1, in_op2, in_tag, mul_res, mul_done, out_ready,
    input  in_ready, mul_ready, mul_op1, mul_op2, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/fp_mul_issue.sv
// rtl/fp_mul_issue.sv - serialising issue stage for the sequential fp multiplier (optional watchdog: FP_MUL_ISSUE_TIMEOUT_EN)
module fp_mul_issue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  fp_mul_issue_if.slave bus,
  output logic          busy,
  output logic          err_timeout
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]      mem_op1 [DEPTH];
  logic [31:0]      mem_op2 [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             done_ok;
  logic             timeout_hit;
  logic [TAG_W-1:0] tag_q;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push          = bus.in_valid && !full;
  assign bus.in_ready  = !full;
  assign busy          = (state != IDLE) || !empty;
  assign done_ok       = (state == WAIT) && bus.mul_done;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state, pop and start pulse; issue only when the result slot will be free
  always_comb begin
    state_nx      = state;
    pop           = 1'b0;
    bus.mul_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (!bus.out_valid || bus.out_ready)) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        bus.mul_ready = 1'b1;
        state_nx      = WAIT;
      end
      WAIT: begin
        if (bus.mul_done || timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op1[wr_ptr[AW-1:0]] <= bus.in_op1;
      mem_op2[wr_ptr[AW-1:0]] <= bus.in_op2;
      mem_tag[wr_ptr[AW-1:0]] <= bus.in_tag;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Operand and tag registers, loaded from the FIFO head and held through WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mul_op1 <= '0;
      bus.mul_op2 <= '0;
      tag_q       <= '0;
    end else if (pop) begin
      bus.mul_op1 <= mem_op1[rd_ptr[AW-1:0]];
      bus.mul_op2 <= mem_op2[rd_ptr[AW-1:0]];
      tag_q       <= mem_tag[rd_ptr[AW-1:0]];
    end
  end

  // Result slot: a capture wins over the consumer's take in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_res   <= '0;
      bus.out_tag   <= '0;
    end else if (done_ok) begin
      bus.out_valid <= 1'b1;
      bus.out_res   <= bus.mul_res;
      bus.out_tag   <= tag_q;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef FP_MUL_ISSUE_TIMEOUT_EN
  localparam logic [8:0] WD_LAST = 9'(TIMEOUT - 1);

  logic [8:0] wd_cnt;

  // Fires on the edge where the count would reach TIMEOUT; a same-cycle done wins
  assign timeout_hit = (state == WAIT) && !bus.mul_done && (wd_cnt == WD_LAST);

  // Watchdog counter restarts on every WAIT entry; error flag is sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ISSUE)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 9'd1;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_issue.sv
// tb/tb_fp_mul_issue.sv - directed bench for fp_mul_issue with a fixed-latency multiplier stand-in
module tb_fp_mul_issue;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic err_timeout;

  always #5 clk = ~clk;

  fp_mul_issue_if #(.TAG_W(4)) bus ();

  fp_mul_issue #(.DEPTH(4), .TAG_W(4), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          stub_cnt = 0;
  bit          stub_en = 1'b1;
  int          n_start = 0;
  int          start_q[$];
  int          done_q[$];
  logic [31:0] s_op1;
  logic [31:0] s_op2;

  logic [31:0] bp_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] bp_r [5] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                            32'h41200000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hand-computed products for the vectors used below
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] k;
    k = {a, b};
    case (k)
      64'h3F800000_40000000: fmul_ref = 32'h40000000;
      64'h40000000_40000000: fmul_ref = 32'h40800000;
      64'h40400000_40000000: fmul_ref = 32'h40C00000;
      64'h40800000_40000000: fmul_ref = 32'h41000000;
      64'h40A00000_40000000: fmul_ref = 32'h41200000;
      64'h40400000_40800000: fmul_ref = 32'h41400000;
      64'h40000000_C0000000: fmul_ref = 32'hC0800000;
      64'h00000000_7F800000: fmul_ref = 32'hFFC00000;
      default:               fmul_ref = 32'hDEADBEEF;
    endcase
  endfunction

  function automatic int q_last(input int q[$]);
    if (q.size() == 0) return -1;
    return q[q.size()-1];
  endfunction

  // Multiplier stand-in: samples operands in the start cycle, done 3 cycles later
  initial begin
    bus.mul_done = 1'b0;
    bus.mul_res  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.mul_done = 1'b0;
      if (!rst) begin
        stub_cnt = 0;
      end else begin
        if (stub_cnt > 0) begin
          stub_cnt--;
          if (stub_cnt == 0 && stub_en) begin
            bus.mul_done = 1'b1;
            bus.mul_res  = fmul_ref(s_op1, s_op2);
            done_q.push_back(cyc);
          end
        end
        if (bus.mul_ready) begin
          n_start++;
          start_q.push_back(cyc);
          s_op1    = bus.mul_op1;
          s_op2    = bus.mul_op2;
          stub_cnt = 3;
        end
      end
    end
  end

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                           output int pc);
    bus.in_valid = 1'b1;
    bus.in_op1   = a;
    bus.in_op2   = b;
    bus.in_tag   = t;
    pc           = cyc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic [3:0] t,
                            output int oc);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    oc = cyc;
    check({tag, "_vld"}, bus.out_valid, 1);
    check({tag, "_res"}, bus.out_res, res);
    check({tag, "_tag"}, bus.out_tag, t);
    tick();
  endtask

  initial begin
    int p, p2, oc, acc, s0, nv;
    bus.in_valid  = 1'b0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset values
    #3;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_mul_ready", bus.mul_ready, 0);
    check("rst_mul_op1", bus.mul_op1, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_res", bus.out_res, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    tick();
    rst = 1'b1;
    tick();

    // Basic product and latencies
    start_q.delete(); done_q.delete();
    s0 = n_start;
    push_pair(32'h3F800000, 32'h40000000, 4'h3, p);
    expect_out("basic", 32'h40000000, 4'h3, oc);
    check("basic_start_lat", q_last(start_q), p + 2);
    check("basic_pulse_w", n_start - s0, 1);
    check("basic_done2out", oc, q_last(done_q) + 1);

    // Back-to-back ordering
    start_q.delete(); done_q.delete();
    push_pair(32'h40400000, 32'h40800000, 4'h5, p);
    push_pair(32'h40000000, 32'hC0000000, 4'h6, p2);
    expect_out("b2b_a", 32'h41400000, 4'h5, oc);
    expect_out("b2b_b", 32'hC0800000, 4'h6, oc);
    check("b2b_starts", start_q.size(), 2);
    if (start_q.size() == 2 && done_q.size() >= 1)
      check("b2b_gap", start_q[1], done_q[0] + 2);

    // Special operands, busy falls once consumed
    push_pair(32'h00000000, 32'h7F800000, 4'h9, p);
    expect_out("nan", 32'hFFC00000, 4'h9, oc);
    check("nan_busy", busy, 0);

    // Backpressure and full
    bus.out_ready = 1'b0;
    s0  = n_start;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op1   = bp_a[i];
      bus.in_op2   = 32'h40000000;
      bus.in_tag   = 4'(i);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("bp_accepted", acc, 5);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_one_start", n_start - s0, 1);
    check("bp_held_vld", bus.out_valid, 1);
    check("bp_held_res", bus.out_res, bp_r[0]);
    check("bp_held_tag", bus.out_tag, 0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_in_ready_back", bus.in_ready, 1);
    for (int k = 1; k < 5; k++)
      expect_out($sformatf("bp_%0d", k), bp_r[k], 4'(k), oc);
    check("bp_busy_end", busy, 0);

    // Reset during WAIT with two entries queued
    stub_en = 1'b0;
    push_pair(32'h40400000, 32'h40000000, 4'h1, p);
    push_pair(32'h40800000, 32'h40000000, 4'h2, p);
    push_pair(32'h40A00000, 32'h40000000, 4'h3, p);
    check("mid_busy", busy, 1);
    check("mid_op_hold", bus.mul_op1, 32'h40400000);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_mul_ready", bus.mul_ready, 0);
    check("mid_rst_mul_op1", bus.mul_op1, 0);
    check("mid_rst_mul_op2", bus.mul_op2, 0);
    check("mid_rst_out_res", bus.out_res, 0);
    check("mid_rst_out_tag", bus.out_tag, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    rst     = 1'b1;
    stub_en = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    check("post_rst_no_out", nv, 0);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Watchdog
    stub_en = 1'b0;
    push_pair(32'h40400000, 32'h40000000, 4'h7, p);
`ifdef FP_MUL_ISSUE_TIMEOUT_EN
    while (cyc < p + 2 + TO) tick();
    check("wd_before", err_timeout, 0);
    tick();
    check("wd_fire", err_timeout, 1);
    check("wd_idle_busy", busy, 0);
    check("wd_no_out", bus.out_valid, 0);
    repeat (3) tick();
    check("wd_sticky", err_timeout, 1);
`else
    repeat (300) tick();
    check("wd_off_err", err_timeout, 0);
    check("wd_off_busy", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
